// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one word-addressed memory port between the fetch port
// (read-only) and the data port (read/write with byte lanes). Every requester strobe
// is captured into a per-port pending slot; one transaction is in flight at a time.
//
// Handshake: requesters raise a one-cycle enable strobe with address/data valid in
// that cycle and receive exactly one one-cycle ack later (read data valid only while
// the ack is high). Toward memory, m_read_enable/m_write_enable is a one-cycle strobe
// and the memory answers with a one-cycle m_read_ack/m_write_ack; acks are accepted
// only while the arbiter is waiting for one.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT       = 64,
  parameter bit          DATA_PRIORITY = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_address,
  input  logic        i_read_enable,
  output logic [31:0] i_read_data,
  output logic        i_read_ack,
  input  logic [31:0] d_address,
  input  logic        d_read_enable,
  input  logic        d_write_enable,
  input  logic [3:0]  d_write_byte_enable,
  input  logic [31:0] d_write_data,
  output logic [31:0] d_read_data,
  output logic        d_read_ack,
  output logic        d_write_ack,
  output logic [31:0] m_address,
  output logic        m_read_enable,
  output logic        m_write_enable,
  output logic [3:0]  m_write_byte_enable,
  output logic [31:0] m_write_data,
  input  logic [31:0] m_read_data,
  input  logic        m_read_ack,
  input  logic        m_write_ack,
  output logic        busy,
  output logic        bus_error,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam int unsigned    CW         = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST   = CW'(TIMEOUT - 1);
  localparam logic [31:0]    ABORT_DATA = 32'hDEAD_BEEF;
  localparam logic           OWN_FETCH  = 1'b0;
  localparam logic           OWN_DATA   = 1'b1;

  state_e         state_q, state_d;
  logic           owner_q, owner_d;
  logic           op_wr_q, op_wr_d;
  logic           rr_last_q, rr_last_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    m_addr_q, m_addr_d;
  logic [3:0]     m_be_q, m_be_d;
  logic [31:0]    m_wdata_q, m_wdata_d;

  logic           f_valid_q, f_valid_d;
  logic [31:0]    f_addr_q, f_addr_d;
  logic           d_valid_q, d_valid_d;
  logic [31:0]    d_addr_q, d_addr_d;
  logic           d_wr_q, d_wr_d;
  logic [3:0]     d_be_q, d_be_d;
  logic [31:0]    d_data_q, d_data_d;
  logic           bus_error_q, bus_error_d;

  logic           in_wait;
  logic           ack_match;
  logic           timeout;
  logic           f_done;
  logic           d_done;
  logic           grant_data;
  logic [31:0]    ret_data;

  // Completion decode: a matching ack wins over a timeout landing in the same cycle.
  always_comb begin
    in_wait    = (state_q == ST_WAIT);
    ack_match  = in_wait && (op_wr_q ? m_write_ack : m_read_ack);
    timeout    = in_wait && !ack_match && (cnt_q == CNT_LAST);
    f_done     = (ack_match || timeout) && (owner_q == OWN_FETCH);
    d_done     = (ack_match || timeout) && (owner_q == OWN_DATA);
    ret_data   = ack_match ? m_read_data : ABORT_DATA;
    grant_data = d_valid_q && (!f_valid_q || DATA_PRIORITY || (rr_last_q == OWN_FETCH));
  end

  // Pending-slot capture: a completing slot may be reloaded in the same cycle.
  always_comb begin
    f_valid_d   = f_valid_q;
    f_addr_d    = f_addr_q;
    d_valid_d   = d_valid_q;
    d_addr_d    = d_addr_q;
    d_wr_d      = d_wr_q;
    d_be_d      = d_be_q;
    d_data_d    = d_data_q;
    bus_error_d = bus_error_q;
    if (f_done) f_valid_d = 1'b0;
    if (d_done) d_valid_d = 1'b0;
    if (i_read_enable) begin
      if (!f_valid_q || f_done) begin
        f_valid_d = 1'b1;
        f_addr_d  = i_address;
      end else begin
        bus_error_d = 1'b1;
      end
    end
    if (d_read_enable || d_write_enable) begin
      if (d_read_enable && d_write_enable) bus_error_d = 1'b1;
      if (!d_valid_q || d_done) begin
        d_valid_d = 1'b1;
        d_addr_d  = d_address;
        d_wr_d    = d_write_enable;
        d_be_d    = d_write_byte_enable;
        d_data_d  = d_write_data;
      end else begin
        bus_error_d = 1'b1;
      end
    end
    if (timeout) bus_error_d = 1'b1;
  end

  // Arbitration FSM next state: grant in IDLE, one-cycle strobe in ISSUE, watchdog in WAIT.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    op_wr_d   = op_wr_q;
    rr_last_d = rr_last_q;
    cnt_d     = cnt_q;
    m_addr_d  = m_addr_q;
    m_be_d    = m_be_q;
    m_wdata_d = m_wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (f_valid_q || d_valid_q) begin
          state_d   = ST_ISSUE;
          owner_d   = grant_data ? OWN_DATA : OWN_FETCH;
          op_wr_d   = grant_data && d_wr_q;
          m_addr_d  = grant_data ? d_addr_q : f_addr_q;
          m_be_d    = grant_data ? d_be_q : 4'h0;
          m_wdata_d = grant_data ? d_data_q : 32'h0;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (ack_match) begin
          state_d   = ST_IDLE;
          rr_last_d = owner_q;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and slot registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_FETCH;
      op_wr_q     <= 1'b0;
      rr_last_q   <= OWN_FETCH;
      cnt_q       <= '0;
      m_addr_q    <= 32'h0;
      m_be_q      <= 4'h0;
      m_wdata_q   <= 32'h0;
      f_valid_q   <= 1'b0;
      f_addr_q    <= 32'h0;
      d_valid_q   <= 1'b0;
      d_addr_q    <= 32'h0;
      d_wr_q      <= 1'b0;
      d_be_q      <= 4'h0;
      d_data_q    <= 32'h0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      op_wr_q     <= op_wr_d;
      rr_last_q   <= rr_last_d;
      cnt_q       <= cnt_d;
      m_addr_q    <= m_addr_d;
      m_be_q      <= m_be_d;
      m_wdata_q   <= m_wdata_d;
      f_valid_q   <= f_valid_d;
      f_addr_q    <= f_addr_d;
      d_valid_q   <= d_valid_d;
      d_addr_q    <= d_addr_d;
      d_wr_q      <= d_wr_d;
      d_be_q      <= d_be_d;
      d_data_q    <= d_data_d;
      bus_error_q <= bus_error_d;
    end
  end

  // Output drive: memory strobes only in ISSUE, requester acks/data only in the completion cycle.
  always_comb begin
    m_address           = m_addr_q;
    m_write_byte_enable = m_be_q;
    m_write_data        = m_wdata_q;
    m_read_enable       = (state_q == ST_ISSUE) && !op_wr_q;
    m_write_enable      = (state_q == ST_ISSUE) && op_wr_q;
    i_read_ack          = f_done;
    i_read_data         = f_done ? ret_data : 32'h0;
    d_read_ack          = d_done && !op_wr_q;
    d_write_ack         = d_done && op_wr_q;
    d_read_data         = (d_done && !op_wr_q) ? ret_data : 32'h0;
    busy                = (state_q != ST_IDLE) || f_valid_q || d_valid_q;
    bus_error           = bus_error_q;
    state_dbg           = state_q;
  end

endmodule
